// File: rtl/status_unit_pkg.sv
// Shared definitions for the flag register and the condition checker it feeds.
package status_unit_pkg;

    // Flag bit positions within the packed {z, c, n, v} vector
    localparam int unsigned FLAG_Z = 3;
    localparam int unsigned FLAG_C = 2;
    localparam int unsigned FLAG_N = 1;
    localparam int unsigned FLAG_V = 0;

    // FSM state encoding
    localparam logic [0:0] NORMAL = 1'b0;
    localparam logic [0:0] IN_EXC = 1'b1;

    // Condition codes as decoded by the condition checker
    localparam logic [3:0] COND_EQ = 4'h0;
    localparam logic [3:0] COND_NE = 4'h1;
    localparam logic [3:0] COND_CS = 4'h2;
    localparam logic [3:0] COND_CC = 4'h3;
    localparam logic [3:0] COND_MI = 4'h4;
    localparam logic [3:0] COND_PL = 4'h5;
    localparam logic [3:0] COND_VS = 4'h6;
    localparam logic [3:0] COND_VC = 4'h7;
    localparam logic [3:0] COND_HI = 4'h8;
    localparam logic [3:0] COND_LS = 4'h9;
    localparam logic [3:0] COND_GE = 4'hA;
    localparam logic [3:0] COND_LT = 4'hB;
    localparam logic [3:0] COND_GT = 4'hC;
    localparam logic [3:0] COND_LE = 4'hD;
    localparam logic [3:0] COND_AL = 4'hE;

    // Evaluate a condition code against a {z, c, n, v} flag vector
    function automatic logic cond_pass(input logic [3:0] cond, input logic [3:0] flags);
        logic z, c, n, v;
        z = flags[FLAG_Z];
        c = flags[FLAG_C];
        n = flags[FLAG_N];
        v = flags[FLAG_V];
        case (cond)
            COND_EQ: cond_pass = z;
            COND_NE: cond_pass = ~z;
            COND_CS: cond_pass = c;
            COND_CC: cond_pass = ~c;
            COND_MI: cond_pass = n;
            COND_PL: cond_pass = ~n;
            COND_VS: cond_pass = v;
            COND_VC: cond_pass = ~v;
            COND_HI: cond_pass = c & ~z;
            COND_LS: cond_pass = ~c | z;
            COND_GE: cond_pass = (n == v);
            COND_LT: cond_pass = (n != v);
            COND_GT: cond_pass = ~z & (n == v);
            COND_LE: cond_pass = z | (n != v);
            default: cond_pass = 1'b1;
        endcase
    endfunction

endpackage

// File: rtl/status_unit.sv
// Architectural flag register with same-cycle forwarding and single-level
// exception save/restore of the flags.
module status_unit
    import status_unit_pkg::*;
#(
    parameter int unsigned CNT_W = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             freeze,
    input  logic             flush,
    input  logic             ex_s,
    input  logic [3:0]       ex_flags,
    input  logic             exc_enter,
    input  logic             exc_return,
    output logic [3:0]       status,
    output logic [3:0]       cond_status,
    output logic             in_exc,
    output logic [CNT_W-1:0] upd_cnt
);

    localparam logic [CNT_W-1:0] CntMax = {CNT_W{1'b1}};

    logic [0:0]       state_q, state_d;
    logic [3:0]       status_q, status_d;
    logic [3:0]       shadow_q, shadow_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;

    logic wr, ent, ret;

    // Qualify requests; freeze gates every one of them
    always_comb begin
        wr  = ex_s & ~flush & ~freeze;
        ent = exc_enter & ~freeze & (state_q == NORMAL);
        ret = exc_return & ~freeze & (state_q == IN_EXC);
    end

    // FSM next state
    always_comb begin
        state_d = state_q;
        if (ent) begin
            state_d = IN_EXC;
        end else if (ret) begin
            state_d = NORMAL;
        end
    end

    // Flag and shadow next state; shadow captures post-edge status so a
    // write coinciding with exception entry is preserved
    always_comb begin
        status_d = status_q;
        if (ret) begin
            status_d = shadow_q;
        end else if (wr) begin
            status_d = ex_flags;
        end
        shadow_d = ent ? status_d : shadow_q;
    end

    // Counter next state; writes overridden by a restore are not counted
    always_comb begin
        cnt_d = cnt_q;
        if (wr && !ret && (cnt_q != CntMax)) begin
            cnt_d = cnt_q + CNT_W'(1);
        end
    end

    // FSM state register
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= NORMAL;
        end else begin
            state_q <= state_d;
        end
    end

    // Flag and shadow registers
    always_ff @(posedge clk) begin
        if (rst) begin
            status_q <= 4'b0000;
            shadow_q <= 4'b0000;
        end else begin
            status_q <= status_d;
            shadow_q <= shadow_d;
        end
    end

    // Saturating update counter
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    // Forwarding mux feeding the condition checker in ID
    always_comb begin
        if (freeze) begin
            cond_status = status_q;
        end else if (ret) begin
            cond_status = shadow_q;
        end else if (ex_s && !flush) begin
            cond_status = ex_flags;
        end else begin
            cond_status = status_q;
        end
    end

    assign status  = status_q;
    assign in_exc  = (state_q == IN_EXC);
    assign upd_cnt = cnt_q;

endmodule
